clock_step_controller: RTL



---
 rtl/clock_step_pkg.sv | 16 +
 rtl/clock_step_controller_if.sv | 13 +
 rtl/clock_enable_negreg.sv | 15 +
 rtl/clock_step_controller.sv | 87 ++++++++
 4 files changed

// File: rtl/clock_step_pkg.sv
// Opcodes and FSM state encodings shared by the clock step controller slice.
// Pure declarations: no latency, no backpressure.
package clock_step_pkg;

  localparam logic [1:0] CMD_NOP  = 2'd0;
  localparam logic [1:0] CMD_RUN  = 2'd1;
  localparam logic [1:0] CMD_HALT = 2'd2;
  localparam logic [1:0] CMD_STEP = 2'd3;

  typedef enum logic [1:0] {
    ST_HALTED   = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_STEPPING = 2'd2
  } state_t;

endpackage

// File: rtl/clock_step_controller_if.sv
// Debug-host command channel (valid/ready) into the clock step controller.
// Wires only: no latency; ready is owned by the slave.
interface clock_step_controller_if #(
  parameter int STEP_WIDTH = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [STEP_WIDTH-1:0] cmd_steps;

  modport master (output cmd_valid, output cmd_op, output cmd_steps, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_steps, output cmd_ready);
endinterface

// File: rtl/clock_enable_negreg.sv
// Falling-edge enable flop feeding the AND clock gate, async active-low clear.
// Latency: d to q at the next falling edge; no backpressure.
module clock_enable_negreg (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= d;
  end

endmodule

// File: rtl/clock_step_controller.sv
// Run/halt/single-step controller producing a glitch-free gate enable and edge count.
// Latency: command at rising edge k gates edges from k+1; never backpressures (ready=1).
module clock_step_controller
  import clock_step_pkg::*;
#(
  parameter int STEP_WIDTH    = 16,
  parameter int COUNT_WIDTH   = 32,
  parameter bit RESET_RUNNING = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  clock_step_controller_if.slave cmd,
  input  logic                   halt_req,
  output logic                   enable_clk,
  output logic                   halted,
  output logic                   step_done,
  output logic                   cmd_dropped,
  output logic [COUNT_WIDTH-1:0] edge_count
);

  localparam state_t RESET_STATE = RESET_RUNNING ? ST_RUNNING : ST_HALTED;

  state_t                state;
  logic [STEP_WIDTH-1:0] remaining;
  logic                  en_next;
  logic                  go_cmd;

  assign cmd.cmd_ready = 1'b1;
  assign go_cmd  = cmd.cmd_valid && ((cmd.cmd_op == CMD_RUN) || (cmd.cmd_op == CMD_STEP));
  assign en_next = (state == ST_RUNNING) || ((state == ST_STEPPING) && (remaining != '0));

  // enable_clk sampled high at a rising edge means that edge reached the core.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RESET_STATE;
      remaining   <= '0;
      halted      <= !RESET_RUNNING;
      step_done   <= 1'b0;
      cmd_dropped <= 1'b0;
      edge_count  <= '0;
    end else begin
      step_done   <= 1'b0;
      cmd_dropped <= 1'b0;
      if (enable_clk) edge_count <= edge_count + COUNT_WIDTH'(1);

      if (halt_req) begin
        state       <= ST_HALTED;
        halted      <= 1'b1;
        remaining   <= '0;
        cmd_dropped <= go_cmd;
      end else if (cmd.cmd_valid && (cmd.cmd_op == CMD_RUN)) begin
        state  <= ST_RUNNING;
        halted <= 1'b0;
      end else if (cmd.cmd_valid && (cmd.cmd_op == CMD_HALT)) begin
        state     <= ST_HALTED;
        halted    <= 1'b1;
        remaining <= '0;
      end else if (cmd.cmd_valid && (cmd.cmd_op == CMD_STEP)) begin
        if (cmd.cmd_steps == '0) begin
          state     <= ST_HALTED;
          halted    <= 1'b1;
          remaining <= '0;
          step_done <= 1'b1;
        end else begin
          state     <= ST_STEPPING;
          halted    <= 1'b0;
          remaining <= cmd.cmd_steps;
        end
      end else if ((state == ST_STEPPING) && enable_clk) begin
        remaining <= remaining - STEP_WIDTH'(1);
        if (remaining == STEP_WIDTH'(1)) begin
          state     <= ST_HALTED;
          halted    <= 1'b1;
          step_done <= 1'b1;
        end
      end
    end
  end

  clock_enable_negreg u_enable_negreg (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (en_next),
    .q     (enable_clk)
  );

endmodule
